// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the instruction-fetch (IF) port and
//   the data (MEM) port. One transaction is in flight at a time. The winner
//   gets its read data with a one-cycle ack. Stall flags tell the pipeline
//   controller which stage is waiting.
//
//   Arbitration: MEM wins over IF unless IF has already lost IF_STARVE_LIMIT
//   arbitrations in a row. A granted transaction that sees no ram_ack within
//   TIMEOUT_CYCLES is aborted. The requester is acked with zero data and the
//   sticky timeout_err flag is set.
//
//   Sequence: IDLE (arbitrate) -> BUSY_I / BUSY_D (ram_req high) -> DONE (ack) -> IDLE.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           IF read request, held until if_ack
//   if_rdata/if_ack          IF read data, valid with the one-cycle if_ack
//   mem_req/mem_we/mem_addr/mem_wdata   data request, held until mem_ack
//   mem_rdata/mem_ack        data read data (0 for writes), valid with mem_ack
//   ram_req/ram_we/ram_addr/ram_wdata   memory request, registered
//   ram_rdata/ram_ack        memory response; ram_ack is ignored outside BUSY
//   stall_if, stall_mem      requester is waiting (req && !ack)
//   timeout_err              sticky; set by any aborted transaction
//
// Optional feature (macro ARB_PERF_EN)
//   Adds perf_if_wait and perf_mem_wait. These 32-bit saturating counters count
//   the cycles with stall_if or stall_mem high. Reset clears them.

module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  parameter int unsigned IF_STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // Instruction-fetch port
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  // Data port
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ack,
  // Memory side
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_ack,
  // Status
  output logic                  stall_if,
  output logic                  stall_mem,
  output logic                  timeout_err
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]           perf_if_wait,
  output logic [31:0]           perf_mem_wait
`endif
);

  // IF_STARVE_LIMIT and TIMEOUT_CYCLES must both be at least 1.
  localparam int unsigned StarveW = $clog2(IF_STARVE_LIMIT + 1);
  localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [StarveW-1:0] StarveMax = StarveW'(IF_STARVE_LIMIT);
  localparam logic [TmoW-1:0]    TmoLast   = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StDone
  } state_e;

  state_e              state_q;
  logic [StarveW-1:0]  starve_q;
  logic [TmoW-1:0]     tmo_q;
  logic                if_win;

  // A starved IF beats a pending MEM request.
  assign if_win = if_req && (!mem_req || (starve_q == StarveMax));

  // The acks are registered, so the stall flags drop in the ack cycle.
  assign stall_if  = if_req  && !if_ack;
  assign stall_mem = mem_req && !mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      tmo_q       <= '0;
      ram_req     <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      if_ack      <= 1'b0;
      mem_ack     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          tmo_q <= '0;
          if (if_win) begin
            state_q   <= StBusyI;
            starve_q  <= '0;
            ram_req   <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= if_addr;
            ram_wdata <= '0;
          end else if (mem_req) begin
            state_q   <= StBusyD;
            ram_req   <= 1'b1;
            ram_we    <= mem_we;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            if (if_req && (starve_q != StarveMax)) begin
              starve_q <= starve_q + 1'b1;
            end
          end
        end

        StBusyI, StBusyD: begin
          if (ram_ack) begin
            state_q <= StDone;
            ram_req <= 1'b0;
            tmo_q   <= '0;
            if (state_q == StBusyI) begin
              if_rdata <= ram_rdata;
              if_ack   <= 1'b1;
            end else begin
              mem_rdata <= ram_we ? '0 : ram_rdata;
              mem_ack   <= 1'b1;
            end
          end else if (tmo_q == TmoLast) begin
            // The memory never answered. Abort the transaction and ack the
            // requester with zero data so that it does not hang.
            state_q     <= StDone;
            ram_req     <= 1'b0;
            tmo_q       <= '0;
            timeout_err <= 1'b1;
            if (state_q == StBusyI) begin
              if_rdata <= '0;
              if_ack   <= 1'b1;
            end else begin
              mem_rdata <= '0;
              mem_ack   <= 1'b1;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        StDone: begin
          // The ack is visible for this cycle only. There is no arbitration
          // here, so the requester has a cycle to drop its req.
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_wait  <= '0;
      perf_mem_wait <= '0;
    end else begin
      if (stall_if && (perf_if_wait != 32'hFFFF_FFFF)) begin
        perf_if_wait <= perf_if_wait + 32'd1;
      end
      if (stall_mem && (perf_mem_wait != 32'hFFFF_FFFF)) begin
        perf_mem_wait <= perf_mem_wait + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        timeout_err;
`ifdef ARB_PERF_EN
  logic [31:0] perf_if_wait;
  logic [31:0] perf_mem_wait;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: acks after `lat` waiting cycles, or never while `hang` is set.
  int          lat  = 0;
  bit          hang = 1'b0;
  int          wait_cnt;
  int          wr_cnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ack      (if_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_ack     (ram_ack),
    .stall_if    (stall_if),
    .stall_mem   (stall_mem),
    .timeout_err (timeout_err)
`ifdef ARB_PERF_EN
    ,
    .perf_if_wait  (perf_if_wait),
    .perf_mem_wait (perf_mem_wait)
`endif
  );

  assign ram_ack   = ram_req && !hang && (wait_cnt == lat);
  assign ram_rdata = (ram_addr == 32'h40) ? 32'h1234_5678 : (ram_addr ^ 32'h5A5A_0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
      wr_cnt   <= 0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wait_cnt <= (ram_req && !ram_ack) ? wait_cnt + 1 : 0;
      if (ram_req && ram_ack && ram_we) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= ram_addr;
        wr_data <= ram_wdata;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Moves from a sample point to 1 ns after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Call at 1 ns after the edge that starts cycle 0. Returns the cycle of the
  // ack (or -1) and how many earlier cycles had ram_req high. Ends at the
  // sample point of the ack cycle.
  task automatic run_until_ack(input bit is_if, input int max_cyc,
                               output int cyc, output int req_cycles);
    cyc        = -1;
    req_cycles = 0;
    for (int c = 0; c < max_cyc; c++) begin
      #4;
      if (is_if ? if_ack : mem_ack) begin
        cyc = c;
        break;
      end
      if (ram_req) req_cycles++;
      next_cycle();
    end
  endtask

  int          cyc;
  int          reqc;
  int          n_ack;
  int          last;
  logic [5:0]  seq;
  bit          both_ack;

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #5;
    check("rst_ram_req", ram_req, 0);
    check("rst_if_ack", if_ack, 0);
    check("rst_mem_ack", mem_ack, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_ram_addr", ram_addr, 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // IF read with an ack in the first ram_req cycle
    if_req  = 1'b1;
    if_addr = 32'h40;
    #4;
    check("t2_c0_stall_if", stall_if, 1);
    check("t2_c0_ram_req", ram_req, 0);
    next_cycle();
    #4;
    check("t2_c1_ram_req", ram_req, 1);
    check("t2_c1_ram_addr", ram_addr, 32'h40);
    check("t2_c1_ram_we", ram_we, 0);
    next_cycle();
    #4;
    check("t2_c2_if_ack", if_ack, 1);
    check("t2_c2_if_rdata", if_rdata, 32'h1234_5678);
    check("t2_c2_stall_if", stall_if, 0);
    check("t2_c2_ram_req", ram_req, 0);
    next_cycle();
    if_req = 1'b0;
    #4;
    check("t2_c3_if_ack", if_ack, 0);
    next_cycle();

    // Simultaneous requests: the MEM write goes first
    if_req    = 1'b1;
    if_addr   = 32'h0;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h10;
    mem_wdata = 32'hA5A5_A5A5;
    next_cycle();
    #4;
    check("t3_c1_ram_we", ram_we, 1);
    check("t3_c1_ram_addr", ram_addr, 32'h10);
    check("t3_c1_ram_wdata", ram_wdata, 32'hA5A5_A5A5);
    next_cycle();
    #4;
    check("t3_c2_mem_ack", mem_ack, 1);
    check("t3_c2_if_ack", if_ack, 0);
    check("t3_c2_mem_rdata", mem_rdata, 0);
    check("t3_c2_stall_if", stall_if, 1);
    next_cycle();
    mem_req = 1'b0;
    mem_we  = 1'b0;
    #4;
    check("t3_c3_ram_req", ram_req, 0);
    next_cycle();
    #4;
    check("t3_c4_ram_req", ram_req, 1);
    check("t3_c4_ram_addr", ram_addr, 32'h0);
    check("t3_c4_ram_we", ram_we, 0);
    next_cycle();
    #4;
    check("t3_c5_if_ack", if_ack, 1);
    check("t3_c5_if_rdata", if_rdata, 32'h5A5A_0000);
    check("t3_wr_cnt", wr_cnt, 1);
    check("t3_wr_data", wr_data, 32'hA5A5_A5A5);
    check("t3_wr_addr", wr_addr, 32'h10);
    next_cycle();
    if_req = 1'b0;
    next_cycle();

    // Starvation: both requests held. The ack order is M M M M I M.
    if_req   = 1'b1;
    if_addr  = 32'h0;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h20;
    seq      = '0;
    n_ack    = 0;
    last     = -1;
    both_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #4;
      if (if_ack && mem_ack) both_ack = 1'b1;
      if (if_ack || mem_ack) begin
        seq[n_ack] = if_ack;
        n_ack++;
        last = c;
      end
      if (n_ack == 6) break;
      next_cycle();
    end
    check("t4_n_ack", n_ack, 6);
    check("t4_ack_order", {26'd0, seq}, 32'b01_0000);
    check("t4_last_cycle", last, 17);
    check("t4_no_dual_ack", both_ack, 0);
    check("t4_mem_rdata", mem_rdata, 32'h5A5A_0020);
    next_cycle();
    if_req  = 1'b0;
    mem_req = 1'b0;
    next_cycle();

    // Timeout on a data read
    check("t5_err_before", timeout_err, 0);
    hang     = 1'b1;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h30;
    run_until_ack(1'b0, 200, cyc, reqc);
    check("t5_ack_cycle", cyc, 65);
    check("t5_req_cycles", reqc, 64);
    check("t5_mem_rdata", mem_rdata, 0);
    check("t5_timeout_err", timeout_err, 1);
    next_cycle();
    mem_req = 1'b0;
    hang    = 1'b0;
    next_cycle();
    if_req  = 1'b1;
    if_addr = 32'h40;
    run_until_ack(1'b1, 20, cyc, reqc);
    check("t5_post_cycle", cyc, 2);
    check("t5_post_rdata", if_rdata, 32'h1234_5678);
    check("t5_err_sticky", timeout_err, 1);
    next_cycle();
    if_req = 1'b0;
    next_cycle();

    // Reset during BUSY_D with a 3-cycle memory delay
    lat      = 3;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h24;
    next_cycle();
    #4;
    check("t6_c1_ram_req", ram_req, 1);
    next_cycle();
    #4;
    check("t6_c2_ram_req", ram_req, 1);
    #2;
    rst     = 1'b1;
    mem_req = 1'b0;
    #1;
    check("t6_async_ram_req", ram_req, 0);
    check("t6_rst_mem_ack", mem_ack, 0);
    check("t6_rst_timeout", timeout_err, 0);
`ifdef ARB_PERF_EN
    check("t6_rst_perf_mem", perf_mem_wait, 0);
`endif
    next_cycle();
    #4;
    check("t6_rst2_mem_ack", mem_ack, 0);
    next_cycle();
    rst = 1'b0;
    #4;
    check("t6_rel_mem_ack", mem_ack, 0);
    check("t6_rel_ram_req", ram_req, 0);
    next_cycle();
    mem_req  = 1'b1;
    mem_addr = 32'h24;
    run_until_ack(1'b0, 20, cyc, reqc);
    check("t6_ack_cycle", cyc, 5);
    check("t6_req_cycles", reqc, 4);
    check("t6_mem_rdata", mem_rdata, 32'h5A5A_0024);
`ifdef ARB_PERF_EN
    check("t6_perf_mem", perf_mem_wait, 5);
    check("t6_perf_if", perf_if_wait, 0);
`endif
    next_cycle();
    mem_req = 1'b0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
